// File: rtl/dcpu16_exu.sv
// dcpu16_exu: execution sequencer for the DCPU16 core.
// Drives the external single-cycle ALU for simple arithmetic and logic ops. It also
// handles DIV/MOD (restoring divider), SHL/SHR (barrel shift) and IFx (comparator)
// locally, and returns registered result, O value, write enables and skip flag.
module dcpu16_exu (
    input  logic        clk,
    input  logic        rst,
    input  logic        stb,
    input  logic [3:0]  opc,
    input  logic [15:0] regA,
    input  logic [15:0] regB,
    output logic        rdy,
    output logic        alu_ena,
    output logic [3:0]  alu_opc,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_R,
    input  logic [15:0] alu_O,
    output logic        done,
    output logic [15:0] regR,
    output logic [15:0] regO,
    output logic        wre,
    output logic        oen,
    output logic        skp
);

    typedef enum logic [1:0] {S_IDLE, S_EXE, S_WB, S_DIV} state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [3:0]  r_opc;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [31:0] r_q;      // dividend bits still to consume, quotient bits shifted in
    logic [15:0] r_rem;
    logic [5:0]  r_cnt;    // divider iterations remaining
    logic [15:0] r_regR;
    logic [15:0] r_regO;
    logic        r_done;
    logic        r_wre;
    logic        r_oen;
    logic        r_skp;

    logic        w_acc;
    logic [16:0] w_trial;
    logic        w_ge;
    logic [15:0] w_rem_nxt;
    logic [31:0] w_q_nxt;
    logic [31:0] w_shl;
    logic [31:0] w_shr;

    // Opcodes executed by the external ALU
    function automatic logic f_is_alu(input logic [3:0] op);
        case (op)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h9, 4'hA, 4'hB: f_is_alu = 1'b1;
            default:                                   f_is_alu = 1'b0;
        endcase
    endfunction

    // {16'h0,a} << b, saturating to zero for shift counts of 32 and above
    function automatic logic [31:0] f_shl(input logic [15:0] a, input logic [15:0] b);
        if (b >= 16'd32) f_shl = 32'h0;
        else             f_shl = {16'h0, a} << b[4:0];
    endfunction

    // {a,16'h0} >> b, saturating to zero for shift counts of 32 and above
    function automatic logic [31:0] f_shr(input logic [15:0] a, input logic [15:0] b);
        if (b >= 16'd32) f_shr = 32'h0;
        else             f_shr = {a, 16'h0} >> b[4:0];
    endfunction

    // IFE/IFN/IFG/IFB condition; the skip flag is its inverse
    function automatic logic f_cond(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            4'hC:    f_cond = (a == b);
            4'hD:    f_cond = (a != b);
            4'hE:    f_cond = (a > b);
            default: f_cond = ((a & b) != 16'h0);
        endcase
    endfunction

    assign w_acc   = stb && rdy;
    assign w_shl   = f_shl(regA, regB);
    assign w_shr   = f_shr(regA, regB);

    // One restoring-division step: the trial remainder fits in 17 bits, the
    // restored remainder is always below b so 16-bit wrapping subtraction is exact.
    assign w_trial   = {r_rem, r_q[31]};
    assign w_ge      = (w_trial >= {1'b0, r_b});
    assign w_rem_nxt = w_ge ? (w_trial[15:0] - r_b) : w_trial[15:0];
    assign w_q_nxt   = {r_q[30:0], w_ge};

    assign alu_opc = r_opc;
    assign alu_a   = r_a;
    assign alu_b   = r_b;
    assign regR    = r_regR;
    assign regO    = r_regO;
    assign done    = r_done;
    assign wre     = r_wre;
    assign oen     = r_oen;
    assign skp     = r_skp;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    if (f_is_alu(opc))
                        w_state_nxt = S_EXE;
                    else if ((opc == 4'h5 || opc == 4'h6) && regB != 16'h0)
                        w_state_nxt = S_DIV;
                end
            end
            S_EXE:   w_state_nxt = S_WB;
            S_WB:    w_state_nxt = S_IDLE;
            S_DIV:   if (r_cnt == 6'd1) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        rdy     = (r_state == S_IDLE);
        alu_ena = (r_state == S_EXE);
    end

    // Operand latches, divider, result registers and one-cycle flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opc  <= 4'h0;
            r_a    <= 16'h0;
            r_b    <= 16'h0;
            r_q    <= 32'h0;
            r_rem  <= 16'h0;
            r_cnt  <= 6'd0;
            r_regR <= 16'h0;
            r_regO <= 16'h0;
            r_done <= 1'b0;
            r_wre  <= 1'b0;
            r_oen  <= 1'b0;
            r_skp  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_wre  <= 1'b0;
            r_oen  <= 1'b0;
            r_skp  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        r_opc <= opc;
                        r_a   <= regA;
                        r_b   <= regB;
                        case (opc)
                            4'h0: r_done <= 1'b1;
                            4'h5: begin
                                if (regB == 16'h0) begin
                                    r_regR <= 16'h0;
                                    r_regO <= 16'h0;
                                    r_done <= 1'b1;
                                    r_wre  <= 1'b1;
                                    r_oen  <= 1'b1;
                                end else begin
                                    r_q   <= {regA, 16'h0};
                                    r_rem <= 16'h0;
                                    r_cnt <= 6'd32;
                                end
                            end
                            4'h6: begin
                                if (regB == 16'h0) begin
                                    r_regR <= 16'h0;
                                    r_done <= 1'b1;
                                    r_wre  <= 1'b1;
                                end else begin
                                    r_q   <= {regA, 16'h0};
                                    r_rem <= 16'h0;
                                    r_cnt <= 6'd16;
                                end
                            end
                            4'h7: begin
                                r_regR <= w_shl[15:0];
                                r_regO <= w_shl[31:16];
                                r_done <= 1'b1;
                                r_wre  <= 1'b1;
                                r_oen  <= 1'b1;
                            end
                            4'h8: begin
                                r_regR <= w_shr[31:16];
                                r_regO <= w_shr[15:0];
                                r_done <= 1'b1;
                                r_wre  <= 1'b1;
                                r_oen  <= 1'b1;
                            end
                            4'hC, 4'hD, 4'hE, 4'hF: begin
                                r_done <= 1'b1;
                                r_skp  <= !f_cond(opc, regA, regB);
                            end
                            default: ;
                        endcase
                    end
                end
                S_WB: begin
                    r_regR <= alu_R;
                    r_done <= 1'b1;
                    r_wre  <= 1'b1;
                    if (r_opc == 4'h2 || r_opc == 4'h3 || r_opc == 4'h4) begin
                        r_regO <= alu_O;
                        r_oen  <= 1'b1;
                    end
                end
                S_DIV: begin
                    r_q   <= w_q_nxt;
                    r_rem <= w_rem_nxt;
                    r_cnt <= r_cnt - 6'd1;
                    if (r_cnt == 6'd1) begin
                        r_done <= 1'b1;
                        r_wre  <= 1'b1;
                        if (r_opc == 4'h5) begin
                            r_regR <= w_q_nxt[31:16];
                            r_regO <= w_q_nxt[15:0];
                            r_oen  <= 1'b1;
                        end else begin
                            r_regR <= w_rem_nxt;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dcpu16_exu.sv
// tb_dcpu16_exu: directed-vector bench for the DCPU16 execution sequencer with a
// behavioural model of the single-cycle ALU.
module tb_dcpu16_exu;

    logic        clk;
    logic        rst;
    logic        stb;
    logic [3:0]  opc;
    logic [15:0] regA;
    logic [15:0] regB;
    logic        rdy;
    logic        alu_ena;
    logic [3:0]  alu_opc;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_R;
    logic [15:0] alu_O;
    logic        done;
    logic [15:0] regR;
    logic [15:0] regO;
    logic        wre;
    logic        oen;
    logic        skp;

    int n_chk  = 0;
    int n_fail = 0;

    int          t_cyc;
    int          t_ena;
    int          t_ena_cyc;
    logic [3:0]  t_ena_opc;
    logic [15:0] t_R;
    logic [15:0] t_O;
    logic        t_wre;
    logic        t_oen;
    logic        t_skp;
    int          n_done;

    dcpu16_exu dut (
        .clk     (clk),
        .rst     (rst),
        .stb     (stb),
        .opc     (opc),
        .regA    (regA),
        .regB    (regB),
        .rdy     (rdy),
        .alu_ena (alu_ena),
        .alu_opc (alu_opc),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_R   (alu_R),
        .alu_O   (alu_O),
        .done    (done),
        .regR    (regR),
        .regO    (regO),
        .wre     (wre),
        .oen     (oen),
        .skp     (skp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-cycle ALU, registered on the enable
    always @(posedge clk) begin
        if (alu_ena) begin
            case (alu_opc)
                4'h1: begin alu_R <= alu_b; alu_O <= 16'h0; end
                4'h2: begin
                    alu_R <= alu_a + alu_b;
                    alu_O <= (({1'b0, alu_a} + {1'b0, alu_b}) > 17'h0FFFF) ? 16'h0001 : 16'h0000;
                end
                4'h3: begin
                    alu_R <= alu_a - alu_b;
                    alu_O <= (alu_a < alu_b) ? 16'hFFFF : 16'h0000;
                end
                4'h4: {alu_O, alu_R} <= {16'h0, alu_a} * {16'h0, alu_b};
                4'h9: begin alu_R <= alu_a & alu_b; alu_O <= 16'h0; end
                4'hA: begin alu_R <= alu_a | alu_b; alu_O <= 16'h0; end
                4'hB: begin alu_R <= alu_a ^ alu_b; alu_O <= 16'h0; end
                default: begin alu_R <= alu_a; alu_O <= 16'h0; end
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Issue one instruction at the current negedge and follow it to done (bounded).
    // inj > 0 raises a stray stb (SET 0x5555,0xAAAA) in that cycle.
    task automatic exec(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input int inj);
        bit got;
        got       = 1'b0;
        stb       = 1'b1;
        opc       = op;
        regA      = a;
        regB      = b;
        t_cyc     = 0;
        t_ena     = 0;
        t_ena_cyc = 0;
        t_ena_opc = 4'h0;
        while (!got && t_cyc < 64) begin
            @(negedge clk);
            t_cyc++;
            stb = 1'b0;
            if (inj > 0 && t_cyc == inj) begin
                stb  = 1'b1;
                opc  = 4'h1;
                regA = 16'h5555;
                regB = 16'hAAAA;
            end
            if (alu_ena) begin
                t_ena++;
                if (t_ena_cyc == 0) t_ena_cyc = t_cyc;
                t_ena_opc = alu_opc;
            end
            if (done) begin
                got   = 1'b1;
                t_R   = regR;
                t_O   = regO;
                t_wre = wre;
                t_oen = oen;
                t_skp = skp;
            end
        end
        stb = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        stb  = 1'b0;
        opc  = 4'h0;
        regA = 16'h0;
        regB = 16'h0;
        #3;
        chk("rst_rdy",  rdy,     1);
        chk("rst_ena",  alu_ena, 0);
        chk("rst_done", done,    0);
        chk("rst_R",    regR,    0);
        chk("rst_O",    regO,    0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // ADD with carry out
        exec(4'h2, 16'hFFFF, 16'h0001, 0);
        chk("add_cyc",     t_cyc,     3);
        chk("add_ena_n",   t_ena,     1);
        chk("add_ena_cyc", t_ena_cyc, 1);
        chk("add_ena_opc", t_ena_opc, 4'h2);
        chk("add_R",   t_R,   16'h0000);
        chk("add_O",   t_O,   16'h0001);
        chk("add_wre", t_wre, 1);
        chk("add_oen", t_oen, 1);
        chk("add_skp", t_skp, 0);

        // SUB issued in ADD's done cycle (back-to-back)
        exec(4'h3, 16'h0003, 16'h0005, 0);
        chk("sub_cyc", t_cyc, 3);
        chk("sub_R",   t_R,   16'hFFFE);
        chk("sub_O",   t_O,   16'hFFFF);
        chk("sub_oen", t_oen, 1);

        // XOR writes R only, O keeps SUB's value
        exec(4'hB, 16'hF0F0, 16'hFF00, 0);
        chk("xor_cyc", t_cyc, 3);
        chk("xor_R",   t_R,   16'h0FF0);
        chk("xor_O",   t_O,   16'hFFFF);
        chk("xor_wre", t_wre, 1);
        chk("xor_oen", t_oen, 0);

        // DIV / MOD
        exec(4'h5, 16'h0007, 16'h0002, 0);
        chk("div_cyc", t_cyc, 33);
        chk("div_R",   t_R,   16'h0003);
        chk("div_O",   t_O,   16'h8000);
        chk("div_wre", t_wre, 1);
        chk("div_oen", t_oen, 1);
        chk("div_ena", t_ena, 0);

        exec(4'h6, 16'h0007, 16'h0002, 0);
        chk("mod_cyc", t_cyc, 17);
        chk("mod_R",   t_R,   16'h0001);
        chk("mod_O",   t_O,   16'h8000);
        chk("mod_wre", t_wre, 1);
        chk("mod_oen", t_oen, 0);

        exec(4'h5, 16'h1234, 16'h0000, 0);
        chk("div0_cyc", t_cyc, 1);
        chk("div0_R",   t_R,   16'h0000);
        chk("div0_O",   t_O,   16'h0000);
        chk("div0_oen", t_oen, 1);

        // Shifts
        exec(4'h7, 16'h8001, 16'd4, 0);
        chk("shl_cyc", t_cyc, 1);
        chk("shl_R",   t_R,   16'h0010);
        chk("shl_O",   t_O,   16'h0008);
        chk("shl_oen", t_oen, 1);

        exec(4'h6, 16'h1234, 16'h0000, 0);
        chk("mod0_cyc", t_cyc, 1);
        chk("mod0_R",   t_R,   16'h0000);
        chk("mod0_O",   t_O,   16'h0008);
        chk("mod0_wre", t_wre, 1);
        chk("mod0_oen", t_oen, 0);

        exec(4'h8, 16'h8001, 16'd4, 0);
        chk("shr_cyc", t_cyc, 1);
        chk("shr_R",   t_R,   16'h0800);
        chk("shr_O",   t_O,   16'h1000);

        // Conditionals
        exec(4'hE, 16'd3, 16'd5, 0);
        chk("ifg_cyc", t_cyc, 1);
        chk("ifg_skp", t_skp, 1);
        chk("ifg_wre", t_wre, 0);
        chk("ifg_oen", t_oen, 0);
        chk("ifg_R",   t_R,   16'h0800);
        chk("ifg_O",   t_O,   16'h1000);

        exec(4'hC, 16'd5, 16'd5, 0);
        chk("ife_skp", t_skp, 0);
        exec(4'hF, 16'h00F0, 16'h0F00, 0);
        chk("ifb_skp", t_skp, 1);
        exec(4'hD, 16'd1, 16'd2, 0);
        chk("ifn_skp", t_skp, 0);

        // Flags drop in the cycle after done
        exec(4'hE, 16'd3, 16'd5, 0);
        @(negedge clk);
        chk("post_done", done, 0);
        chk("post_skp",  skp,  0);

        exec(4'h7, 16'h8001, 16'd40, 0);
        chk("shl40_cyc", t_cyc, 1);
        chk("shl40_R",   t_R,   16'h0000);
        chk("shl40_O",   t_O,   16'h0000);

        exec(4'h0, 16'h1111, 16'h2222, 0);
        chk("nop_cyc", t_cyc, 1);
        chk("nop_wre", t_wre, 0);
        chk("nop_oen", t_oen, 0);
        chk("nop_skp", t_skp, 0);

        // Stray stb during DIV iteration 5 is ignored
        exec(4'h5, 16'h0007, 16'h0002, 5);
        chk("divinj_cyc", t_cyc, 33);
        chk("divinj_R",   t_R,   16'h0003);
        chk("divinj_O",   t_O,   16'h8000);
        chk("divinj_ena", t_ena, 0);

        // Asynchronous reset in the middle of a DIV
        stb  = 1'b1;
        opc  = 4'h5;
        regA = 16'h0007;
        regB = 16'h0002;
        @(negedge clk);
        stb = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_rdy",  rdy,     1);
        chk("arst_ena",  alu_ena, 0);
        chk("arst_done", done,    0);
        chk("arst_wre",  wre,     0);
        chk("arst_oen",  oen,     0);
        chk("arst_skp",  skp,     0);
        chk("arst_R",    regR,    0);
        chk("arst_O",    regO,    0);
        chk("arst_a",    alu_a,   0);
        chk("arst_b",    alu_b,   0);
        chk("arst_opc",  alu_opc, 0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("arst_nodone", n_done, 0);

        // DIV after reset completes normally
        exec(4'h5, 16'h0007, 16'h0003, 0);
        chk("div2_cyc", t_cyc, 33);
        chk("div2_R",   t_R,   16'h0002);
        chk("div2_O",   t_O,   16'h5555);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dcpu16_exu.md
# dcpu16_exu

Execution sequencer for the DCPU16 core. It accepts one basic instruction at a time (opcode plus resolved operands a and b), sequences the single-cycle ALU for SET/ADD/SUB/MUL/AND/BOR/XOR, and handles the remaining opcodes internally:

- DIV/MOD: iterative restoring divider.
- SHL/SHR: one-cycle barrel shift.
- IFE/IFN/IFG/IFB: comparator.

It returns a registered result, an O-register value, write enables and a skip flag to the core's writeback/PC logic.

## Interface
Parameters: none.

- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- stb  in  1  issue strobe; instruction accepted on a rising edge with stb=1 and rdy=1
- opc  in  4  basic opcode (0x0 non-basic/NOP, 0x1–0xF per DCPU16 spec)
- regA  in  16  operand a (destination value)
- regB  in  16  operand b (source value)
- rdy  out  1  combinational, 1 when in IDLE
- alu_ena  out  1  enable to single-cycle ALU
- alu_opc  out  4  opcode to ALU
- alu_a, alu_b  out  16  operands to ALU
- alu_R, alu_O  in  16  ALU registered result and overflow
- done  out  1  one-cycle pulse: result outputs valid
- regR  out  16  result for a
- regO  out  16  O-register value
- wre  out  1  write regR to a (qualified by done)
- oen  out  1  write regO to O (qualified by done)
- skp  out  1  skip next instruction (qualified by done)

## Operation
- States: IDLE, EXE, WB, DIV.
- On acceptance, latch opc, regA and regB. Inputs are ignored at all other times.
- stb while rdy=0 is ignored; there is no queue.
- ALU ops (opc 1,2,3,4,9,A,B):
  - IDLE→EXE, with alu_opc/alu_a/alu_b driven from the latches.
  - EXE: alu_ena=1 for exactly one cycle, then →WB.
  - WB: capture alu_R/alu_O into regR/regO, then →IDLE with done.
  - wre=1 for all ALU ops.
  - oen=1 only for ADD/SUB/MUL; the ALU's O is undefined for the other ops.
- DIV (5), b≠0: 32-iteration restoring division of the 32-bit dividend {a,16'h0} by b, one quotient bit per cycle in DIV.
  - regR = quotient[31:16] (a/b).
  - regO = quotient[15:0] (((a<<16)/b)&0xFFFF).
  - wre=1, oen=1.
- MOD (6), b≠0: 16 iterations on dividend a.
  - regR = remainder.
  - wre=1, oen=0; regO is unchanged.
- DIV/MOD with b=0: no iterations, done next cycle.
  - DIV: regR=0, regO=0, wre=1, oen=1.
  - MOD: regR=0, wre=1, oen=0.
- SHL (7): s = {16'h0,a} << b.
  - regR = s[15:0], regO = s[31:16].
  - b ≥ 32 gives both 0.
  - wre=1, oen=1.
- SHR (8): s = {a,16'h0} >> b.
  - regR = s[31:16], regO = s[15:0].
  - b ≥ 32 gives both 0.
  - wre=1, oen=1.
- IFE/IFN/IFG/IFB (C–F): conditions are a==b, a!=b, a>b (unsigned) and (a&b)!=0 respectively.
  - skp = NOT condition.
  - wre=0, oen=0; regR/regO are unchanged.
- opc 0: done with wre=oen=skp=0.
- Flags: done, wre, oen and skp are registered and valid only in the done cycle. All four clear to 0 in every cycle without done.
- regR/regO hold their value until overwritten.

## Timing
- Accept edge = edge 0. The done cycle is:
  - cycle 1 for opc 0, 7, 8, C–F and divide-by-zero
  - cycle 3 for ALU ops (alu_ena in cycle 1)
  - cycle 17 for MOD
  - cycle 33 for DIV
- rdy=1 in the done cycle, so back-to-back issue is allowed: a stb in the done cycle is accepted.
- Reset (asynchronous, immediate, including mid-operation):
  - state=IDLE and rdy=1.
  - regR, regO, alu_a, alu_b = 0; alu_opc = 0.
  - alu_ena, done, wre, oen, skp = 0.
  - Any partial result is discarded and no done is issued.
- alu_ena is never high outside EXE, and never high during or after reset.

## Test plan
- ADD a=0xFFFF b=0x0001 with a behavioural ALU model, stb at cycle 0 → alu_ena=1 only in cycle 1 with alu_opc=2; done in cycle 3 with regR=0x0000, regO=0x0001, wre=1, oen=1, skp=0.
- DIV a=7 b=2 → done in cycle 33, regR=0x0003, regO=0x8000, oen=1. MOD a=7 b=2 → done in cycle 17, regR=0x0001, oen=0, regO unchanged.
- Divide by zero: DIV a=0x1234 b=0 → done in cycle 1, regR=0, regO=0. MOD a=0x1234 b=0 → done in cycle 1, regR=0, oen=0.
- Shifts:
  - SHL a=0x8001 b=4 → regR=0x0010, regO=0x0008.
  - SHR a=0x8001 b=4 → regR=0x0800, regO=0x1000.
  - SHL with b=40 → regR=0, regO=0.
  - All done in cycle 1.
- Conditionals:
  - IFG a=3 b=5 → skp=1, wre=0.
  - IFE a=5 b=5 → skp=0.
  - IFB a=0x00F0 b=0x0F00 → skp=1.
  - IFN a=1 b=2 → skp=0.
- Handshake and reset:
  - stb asserted during DIV iteration 5 is ignored (result unchanged).
  - stb during the done cycle is accepted (back-to-back).
  - rst pulsed asynchronously mid-DIV → all outputs 0 and rdy=1 immediately, no done pulse follows; the next DIV after reset completes normally.
